// File: rtl/serial_paralelo.sv
// serial_paralelo: COM-aligned serial-to-parallel deserializer with lock detection
module serial_paralelo #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] COM = 8'hBC,
  parameter int COM_NEEDED = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic [2:0]       com_count
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] NEED = 3'(COM_NEEDED);
  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       com_d;
  logic             bnd, is_com;
  assign shift_d = {shift_q[WIDTH-2:0], data_in};
  assign bnd     = cnt_q == LAST;
  assign is_com  = shift_d == COM;
  assign com_d   = com_count + 3'd1;
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      state_q   <= SEARCH;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      com_count <= '0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= bnd ? '0 : cnt_q + CW'(1);
      valid_out <= 1'b0;
      case (state_q)
        SEARCH: if (is_com) begin
          cnt_q     <= '0;
          com_count <= 3'd1;
          state_q   <= NEED == 3'd1 ? ACTIVE : ALIGN;
          active    <= NEED == 3'd1;
        end
        ALIGN: if (bnd) begin
          com_count <= is_com ? com_d : 3'd0;
          state_q   <= !is_com ? SEARCH : com_d == NEED ? ACTIVE : ALIGN;
          active    <= is_com && com_d == NEED;
        end
        default: if (bnd && !is_com) begin
          data_out  <= shift_d;
          valid_out <= 1'b1;
        end
      endcase
    end
  end
endmodule
